// File: rtl/wbm_cmd_initiator_pkg.sv
// Shared WISHBONE widths, status codes and FSM states
// for the command initiator.
package wbm_cmd_initiator_pkg;

  localparam int WB_AW = 20;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_ERR       = 2'b01,
    ST_RETRY_EXH = 2'b10,
    ST_TIMEOUT   = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_BUS     = 2'b01,
    S_BACKOFF = 2'b10,
    S_RESP    = 2'b11
  } state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/wbm_cmd_initiator_if.sv
// Command, response and WISHBONE master signal bundle.
// Signal suffixes are relative to the initiator.
interface wbm_cmd_initiator_if;
  import wbm_cmd_initiator_pkg::*;

  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_we_i;
  logic [WB_AW-1:0] cmd_adr_i;
  logic [WB_DW-1:0] cmd_dat_i;
  logic [WB_SW-1:0] cmd_sel_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WB_DW-1:0] rsp_dat_o;
  logic [1:0]       rsp_status_o;

  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic [WB_AW-1:0] adr_o;
  logic [WB_DW-1:0] dat_o;
  logic [WB_SW-1:0] sel_o;
  logic [WB_DW-1:0] dat_i;
  logic             ack_i;
  logic             err_i;
  logic             rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i,
    input  cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o,
    output rsp_status_o,
    input  rsp_ready_i,
    output cyc_o, stb_o, we_o,
    output adr_o, dat_o, sel_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i,
    output cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o,
    input  rsp_status_o,
    output rsp_ready_i,
    input  cyc_o, stb_o, we_o,
    input  adr_o, dat_o, sel_o,
    output dat_i, ack_i, err_i, rty_i
  );

endinterface

// File: rtl/wbm_timeout_ctr.sv
// Per-attempt bus-cycle watchdog: counts enabled
// clocks, flags the clock on which LIMIT is reached.
module wbm_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q;
  logic        last;

  assign last      = (cnt_q == 16'(LIMIT - 1));
  assign expired_o = en_i && last;

  // Clear wins; otherwise count enabled clocks, saturating.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !last) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/wbm_cmd_initiator.sv
// Turns channel commands into WISHBONE classic cycles
// with retry, backoff and per-attempt timeout.
module wbm_cmd_initiator
  import wbm_cmd_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input logic             clk_i,
  input logic             rst_n_i,
  wbm_cmd_initiator_if.master bus
);

  state_e           state_q;
  cmd_t             cmd_q;
  logic [3:0]       retry_q;
  logic             cmd_ready_q;
  logic             cyc_q;
  logic             stb_q;
  logic             we_q;
  logic [WB_AW-1:0] adr_q;
  logic [WB_DW-1:0] dat_q;
  logic [WB_SW-1:0] sel_q;
  logic             rsp_valid_q;
  logic [WB_DW-1:0] rsp_dat_q;
  status_e          rsp_status_q;

  logic accept;
  logic term;
  logic tmo_clr;
  logic tmo_en;
  logic tmo_exp;
  cmd_t cmd_in;

  assign cmd_in = '{we:  bus.cmd_we_i,
                    adr: bus.cmd_adr_i,
                    dat: bus.cmd_dat_i,
                    sel: bus.cmd_sel_i};

  assign accept = (state_q == S_IDLE)
               && cmd_ready_q
               && bus.cmd_valid_i;

  assign term = bus.err_i | bus.rty_i
              | bus.ack_i | tmo_exp;

  assign tmo_clr = accept
                || (state_q == S_BACKOFF);
  assign tmo_en  = (state_q == S_BUS);

  wbm_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_exp)
  );

  // Command FSM; every bus and channel output is a register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      retry_q      <= '0;
      cmd_ready_q  <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_q       <= cmd_in;
            retry_q     <= '0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= cmd_in.we;
            adr_q       <= cmd_in.adr;
            dat_q       <= cmd_in.dat;
            sel_q       <= cmd_in.sel;
            state_q     <= S_BUS;
          end
        end
        S_BUS: begin
          if (term) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_dat_q   <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
            if (bus.err_i) begin
              rsp_status_q <= ST_ERR;
            end else if (bus.rty_i &&
                (retry_q < 4'(MAX_RETRY))) begin
              retry_q     <= retry_q + 4'd1;
              rsp_valid_q <= 1'b0;
              state_q     <= S_BACKOFF;
            end else if (bus.rty_i) begin
              rsp_status_q <= ST_RETRY_EXH;
            end else if (bus.ack_i) begin
              rsp_status_q <= ST_OK;
              rsp_dat_q    <= cmd_q.we ? '0
                                       : bus.dat_i;
            end else begin
              rsp_status_q <= ST_TIMEOUT;
            end
          end
        end
        S_BACKOFF: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= cmd_q.we;
          adr_q   <= cmd_q.adr;
          dat_q   <= cmd_q.dat;
          sel_q   <= cmd_q.sel;
          state_q <= S_BUS;
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
            cmd_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.cyc_o        = cyc_q;
  assign bus.stb_o        = stb_q;
  assign bus.we_o         = we_q;
  assign bus.adr_o        = adr_q;
  assign bus.dat_o        = dat_q;
  assign bus.sel_o        = sel_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_wbm_cmd_initiator.sv
// Directed bench for wbm_cmd_initiator: vector table
// plus hand sequences for reset and stall corners.
module tb_wbm_cmd_initiator;

  logic clk;
  logic rst_n;

  wbm_cmd_initiator_if bus_if ();

  wbm_cmd_initiator #(
    .TIMEOUT   (8),
    .MAX_RETRY (3)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    T_NONE, T_ACK, T_ERR, T_RTY,
    T_ACKERR, T_RTYACK, T_ERRRTY, T_RTY1ACK
  } term_e;

  typedef struct {
    logic        we;
    logic [19:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    term_e       term;
    int          waits;
    logic [31:0] rdat;
    logic [1:0]  e_st;
    logic [31:0] e_dat;
    int          e_cyc;
    int          e_att;
    int          e_gap;
    int          e_lat;
  } vec_t;

  vec_t vecs[10];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_term();
    bus_if.ack_i = 1'b0;
    bus_if.err_i = 1'b0;
    bus_if.rty_i = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (bus_if.cmd_ready_o !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk({nm, "_ready"}, 32'(bus_if.cmd_ready_o), 1);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int cyc_n, att, gap, lat, wcnt;
    bit prev, done, bad;
    string nm;
    v = vecs[idx];
    nm = $sformatf("v%0d", idx);
    bus_if.cmd_we_i  = v.we;
    bus_if.cmd_adr_i = v.adr;
    bus_if.cmd_dat_i = v.dat;
    bus_if.cmd_sel_i = v.sel;
    bus_if.dat_i     = v.rdat;
    bus_if.cmd_valid_i = 1'b1;
    wait_ready(nm);
    step();
    bus_if.cmd_valid_i = 1'b0;
    cyc_n = 0; att = 0; gap = 0; lat = 0;
    wcnt = 0; prev = 0; done = 0; bad = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (bus_if.rsp_valid_o === 1'b1) begin
        done = 1;
      end else begin
        clr_term();
        if (bus_if.cyc_o === 1'b1) begin
          if (!prev) begin
            att++;
            wcnt = 0;
          end
          cyc_n++;
          if (bus_if.stb_o !== 1'b1 ||
              bus_if.we_o !== v.we ||
              bus_if.adr_o !== v.adr ||
              bus_if.dat_o !== v.dat ||
              bus_if.sel_o !== v.sel)
            bad = 1;
          if (wcnt == v.waits) begin
            case (v.term)
              T_ACK: bus_if.ack_i = 1'b1;
              T_ERR: bus_if.err_i = 1'b1;
              T_RTY: bus_if.rty_i = 1'b1;
              T_ACKERR: begin
                bus_if.ack_i = 1'b1;
                bus_if.err_i = 1'b1;
              end
              T_RTYACK: begin
                bus_if.rty_i = 1'b1;
                bus_if.ack_i = 1'b1;
              end
              T_ERRRTY: begin
                bus_if.err_i = 1'b1;
                bus_if.rty_i = 1'b1;
              end
              T_RTY1ACK: begin
                if (att == 1) bus_if.rty_i = 1'b1;
                else bus_if.ack_i = 1'b1;
              end
              default: ;
            endcase
          end
          wcnt++;
        end else begin
          gap++;
          if (bus_if.stb_o !== 1'b0 ||
              bus_if.we_o !== 1'b0 ||
              bus_if.adr_o !== '0 ||
              bus_if.dat_o !== '0 ||
              bus_if.sel_o !== '0)
            bad = 1;
        end
        prev = bus_if.cyc_o;
        step();
        lat++;
      end
    end
    clr_term();
    chk({nm, "_done"}, 32'(done), 1);
    chk({nm, "_status"},
        32'(bus_if.rsp_status_o), 32'(v.e_st));
    chk({nm, "_rdat"}, bus_if.rsp_dat_o, v.e_dat);
    chk({nm, "_cyc_clks"}, cyc_n, v.e_cyc);
    chk({nm, "_attempts"}, att, v.e_att);
    chk({nm, "_gaps"}, gap, v.e_gap);
    chk({nm, "_latency"}, lat, v.e_lat);
    chk({nm, "_bus_stable"}, 32'(bad), 0);
    chk({nm, "_busy_ready"},
        32'(bus_if.cmd_ready_o), 0);
    bus_if.rsp_ready_i = 1'b1;
    step();
    bus_if.rsp_ready_i = 1'b0;
    chk({nm, "_rsp_drop"},
        32'(bus_if.rsp_valid_o), 0);
    chk({nm, "_ready_back"},
        32'(bus_if.cmd_ready_o), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{1'b0, 20'h10004, 32'h0, 4'hF, T_ACK, 0,
                32'hDEADBEEF, 2'b00, 32'hDEADBEEF,
                1, 1, 0, 1};
    vecs[1] = '{1'b1, 20'h80000, 32'h12345678, 4'hF,
                T_ACK, 3, 32'hCAFEF00D, 2'b00, 32'h0,
                4, 1, 0, 4};
    vecs[2] = '{1'b0, 20'h00100, 32'h0, 4'h3, T_RTY, 0,
                32'h11112222, 2'b10, 32'h0,
                4, 4, 3, 7};
    vecs[3] = '{1'b0, 20'h00200, 32'h0, 4'h1, T_NONE, 0,
                32'h33334444, 2'b11, 32'h0,
                8, 1, 0, 8};
    vecs[4] = '{1'b1, 20'h00300, 32'hA5A5A5A5, 4'hC,
                T_ACKERR, 1, 32'h55556666, 2'b01, 32'h0,
                2, 1, 0, 2};
    vecs[5] = '{1'b0, 20'h00400, 32'h0, 4'hF, T_ERR, 0,
                32'hAAAA5555, 2'b01, 32'h0,
                1, 1, 0, 1};
    vecs[6] = '{1'b0, 20'h00500, 32'h0, 4'hF,
                T_RTY1ACK, 0, 32'h01234567, 2'b00,
                32'h01234567, 2, 2, 1, 3};
    vecs[7] = '{1'b0, 20'h00600, 32'h0, 4'h2,
                T_RTYACK, 2, 32'h77778888, 2'b10, 32'h0,
                12, 4, 3, 15};
    vecs[8] = '{1'b0, 20'hFFFFF, 32'h0, 4'hF, T_ACK, 7,
                32'h89ABCDEF, 2'b00, 32'h89ABCDEF,
                8, 1, 0, 8};
    vecs[9] = '{1'b0, 20'h00700, 32'h0, 4'h8,
                T_ERRRTY, 0, 32'h9999AAAA, 2'b01, 32'h0,
                1, 1, 0, 1};

    rst_n = 1'b0;
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_we_i    = 1'b0;
    bus_if.cmd_adr_i   = '0;
    bus_if.cmd_dat_i   = '0;
    bus_if.cmd_sel_i   = '0;
    bus_if.rsp_ready_i = 1'b0;
    bus_if.dat_i       = '0;
    clr_term();
    step();
    step();
    chk("rst_ready", 32'(bus_if.cmd_ready_o), 0);
    chk("rst_cyc", 32'(bus_if.cyc_o), 0);
    chk("rst_stb", 32'(bus_if.stb_o), 0);
    chk("rst_adr", 32'(bus_if.adr_o), 0);
    chk("rst_rsp_valid",
        32'(bus_if.rsp_valid_o), 0);
    chk("rst_rsp_dat", bus_if.rsp_dat_o, 0);
    chk("rst_status", 32'(bus_if.rsp_status_o), 0);
    rst_n = 1'b1;
    step();
    chk("rel_ready", 32'(bus_if.cmd_ready_o), 1);

    // Spurious terminators while idle do nothing.
    bus_if.ack_i = 1'b1;
    bus_if.err_i = 1'b1;
    bus_if.rty_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus_if.cyc_o !== 1'b0 ||
          bus_if.rsp_valid_o !== 1'b0 ||
          bus_if.cmd_ready_o !== 1'b1)
        bad++;
    end
    clr_term();
    chk("spurious_idle", bad, 0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Response stall: data held, no new acceptance.
    bus_if.cmd_we_i  = 1'b0;
    bus_if.cmd_adr_i = 20'h00040;
    bus_if.cmd_sel_i = 4'hF;
    bus_if.dat_i     = 32'h0BADF00D;
    bus_if.cmd_valid_i = 1'b1;
    wait_ready("stall");
    step();
    bus_if.ack_i = 1'b1;
    step();
    bus_if.ack_i = 1'b0;
    bus_if.dat_i = 32'h0;
    chk("stall_valid", 32'(bus_if.rsp_valid_o), 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus_if.rsp_valid_o !== 1'b1 ||
          bus_if.rsp_dat_o !== 32'h0BADF00D ||
          bus_if.rsp_status_o !== 2'b00 ||
          bus_if.cmd_ready_o !== 1'b0 ||
          bus_if.cyc_o !== 1'b0)
        bad++;
    end
    chk("stall_hold", bad, 0);
    bus_if.rsp_ready_i = 1'b1;
    step();
    bus_if.rsp_ready_i = 1'b0;
    chk("b2b_ready", 32'(bus_if.cmd_ready_o), 1);
    chk("b2b_no_cyc_yet", 32'(bus_if.cyc_o), 0);
    step();
    bus_if.cmd_valid_i = 1'b0;
    chk("b2b_cyc", 32'(bus_if.cyc_o), 1);
    bus_if.ack_i = 1'b1;
    step();
    bus_if.ack_i = 1'b0;
    bus_if.rsp_ready_i = 1'b1;
    step();
    bus_if.rsp_ready_i = 1'b0;

    // Reset while the bus cycle is open.
    bus_if.cmd_adr_i = 20'h00ABC;
    bus_if.cmd_valid_i = 1'b1;
    wait_ready("rstbus");
    step();
    bus_if.cmd_valid_i = 1'b0;
    step();
    step();
    chk("rstbus_cyc_open", 32'(bus_if.cyc_o), 1);
    rst_n = 1'b0;
    step();
    chk("rstbus_cyc", 32'(bus_if.cyc_o), 0);
    chk("rstbus_stb", 32'(bus_if.stb_o), 0);
    rst_n = 1'b1;
    bus_if.ack_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_if.rsp_valid_o !== 1'b0 ||
          bus_if.cyc_o !== 1'b0)
        bad++;
    end
    clr_term();
    chk("rstbus_no_rsp", bad, 0);
    chk("rstbus_ready", 32'(bus_if.cmd_ready_o), 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
